// File: rtl/aes_key_pkg.sv
// Shared AES-256 key-schedule definitions.
// Contents: schedule sizes, FSM state type, round-key type, S-box lookup,
// and the word-substitution helper used by the expansion step.
package aes_key_pkg;

    localparam int NUM_ROUND_KEYS = 15;
    localparam int EXPAND_STEPS   = 7;
    localparam logic [3:0] LAST_STEP = 4'(EXPAND_STEPS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        DONE   = 2'd2
    } state_t;

    typedef logic [127:0] round_key_t;

    // Byte 0x00 sits in the most significant byte of the constant.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry b lives at bit 2047-8*b, which is simply {~b, 3'b111}.
    function automatic logic [7:0] sub_byte(input logic [7:0] b);
        return SBOX[{~b, 3'b111} -: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sub_byte(w[31:24]), sub_byte(w[23:16]),
                sub_byte(w[15:8]),  sub_byte(w[7:0])};
    endfunction

endpackage

// File: rtl/key_schedule_seq_if.sv
// Key-load and round-key read bus of the key scheduler.
// master: key source / round-key consumer. slave: key_schedule_seq.
interface key_schedule_seq_if;
    logic [255:0] key;
    logic         key_valid;
    logic         key_ready;
    logic         busy;
    logic         keys_valid;
    logic [3:0]   rk_idx;
    logic [127:0] rk;

    modport master (
        output key, key_valid, rk_idx,
        input  key_ready, busy, keys_valid, rk
    );

    modport slave (
        input  key, key_valid, rk_idx,
        output key_ready, busy, keys_valid, rk
    );
endinterface

// File: rtl/key_schedule_seq_keygen.sv
// Combinational AES-256 KeyGenerate: from eight schedule words (w0 in the
// MSBs) produce the next eight words.
// Ports: work (current 256-bit window), step (rcon index 0..6), next.
module key_schedule_seq_keygen
    import aes_key_pkg::*;
(
    input  logic [255:0] work,
    input  logic [3:0]   step,
    output logic [255:0] next
);
    logic [31:0] w [8];
    logic [31:0] n [8];
    logic [31:0] rot_sub;
    logic [31:0] mid_sub;
    logic [7:0]  rcon;

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            w[i] = work[255 - 32*i -: 32];
        end
        // rcon is a power of two for indices 0..6, so no GF doubling needed.
        rcon    = 8'h01 << step[2:0];
        rot_sub = sub_word({w[7][23:0], w[7][31:24]}) ^ {rcon, 24'h0};
        n[0]    = w[0] ^ rot_sub;
        n[1]    = w[1] ^ n[0];
        n[2]    = w[2] ^ n[1];
        n[3]    = w[3] ^ n[2];
        // AES-256 specific: the middle word gets SubWord without rotation.
        mid_sub = sub_word(n[3]);
        n[4]    = w[4] ^ mid_sub;
        n[5]    = w[5] ^ n[4];
        n[6]    = w[6] ^ n[5];
        n[7]    = w[7] ^ n[6];
        next    = {n[0], n[1], n[2], n[3], n[4], n[5], n[6], n[7]};
    end
endmodule

// File: rtl/key_schedule_seq.sv
// Sequential AES-256 key scheduler: accepts a 256-bit key, expands it over
// seven cycles into 15 stored round keys, serves them by index with one
// cycle of read latency.
// Ports: clk, rst_n (synchronous, active low), bus (key load, status,
// round-key read).
//
// state  | meaning
// IDLE   | no key expanded yet; ready for a key
// EXPAND | one KeyGenerate step per cycle, steps 0..6
// DONE   | all 15 round keys valid; a new key restarts expansion
module key_schedule_seq
    import aes_key_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    key_schedule_seq_if.slave  bus
);
    state_t       state_q, state_d;
    logic         accept;
    logic         expanding;
    round_key_t   slot_q [NUM_ROUND_KEYS];
    logic [255:0] work_q;
    logic [255:0] next_key;
    logic [3:0]   step_q;
    logic [3:0]   even_idx;
    logic [3:0]   odd_idx;
    round_key_t   rk_q;

    key_schedule_seq_keygen u_keygen (
        .work (work_q),
        .step (step_q),
        .next (next_key)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        expanding = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (bus.key_valid) begin
                    accept  = 1'b1;
                    state_d = EXPAND;
                end
            end
            EXPAND: begin
                expanding = 1'b1;
                if (step_q == LAST_STEP) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign even_idx = {step_q[2:0], 1'b0} + 4'd2;
    assign odd_idx  = even_idx + 4'd1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_ROUND_KEYS; i++) begin
                slot_q[i] <= '0;
            end
            work_q <= '0;
            step_q <= '0;
        end else if (accept) begin
            slot_q[0] <= bus.key[255:128];
            slot_q[1] <= bus.key[127:0];
            work_q    <= bus.key;
            step_q    <= '0;
        end else if (expanding) begin
            slot_q[even_idx] <= next_key[255:128];
            // The final step's lower half would be slot 15, which does not exist.
            if (step_q != LAST_STEP) begin
                slot_q[odd_idx] <= next_key[127:0];
                step_q          <= step_q + 4'd1;
            end
            work_q <= next_key;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rk_q <= '0;
        end else if (bus.rk_idx == 4'd15) begin
            rk_q <= '0;
        end else begin
            rk_q <= slot_q[bus.rk_idx];
        end
    end

    assign bus.rk         = rk_q;
    assign bus.key_ready  = (state_q != EXPAND);
    assign bus.busy       = (state_q == EXPAND);
    assign bus.keys_valid = (state_q == DONE);
endmodule

// File: tb/tb_key_schedule_seq.sv
module tb_key_schedule_seq;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;

    localparam logic [255:0] FIPS_KEY =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] OTHER_KEY =
        256'hdeadbeefcafef00d0123456789abcdeffedcba98765432100f1e2d3c4b5a6978;

    key_schedule_seq_if bus ();

    key_schedule_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_rk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [127:0] exp_rk;
        rst_n         = 1'b0;
        bus.key       = '0;
        bus.key_valid = 1'b0;
        bus.rk_idx    = 4'd0;
        tick();
        tick();
        check_bit("reset_keys_valid", bus.keys_valid, 1'b0);
        check_bit("reset_key_ready", bus.key_ready, 1'b1);
        check_bit("reset_busy", bus.busy, 1'b0);
        check_rk("reset_rk", bus.rk, 128'h0);
        rst_n = 1'b1;
        tick();
        check_bit("idle_key_ready", bus.key_ready, 1'b1);

        // Accept FIPS key, then hold a different key valid during expansion.
        bus.key       = FIPS_KEY;
        bus.key_valid = 1'b1;
        tick();
        check_bit("accept_busy", bus.busy, 1'b1);
        check_bit("accept_key_ready", bus.key_ready, 1'b0);
        bus.key = OTHER_KEY;
        for (int i = 1; i <= 6; i++) begin
            tick();
            check_bit($sformatf("expand_busy_%0d", i), bus.busy, 1'b1);
            check_bit($sformatf("expand_kv_%0d", i), bus.keys_valid, 1'b0);
        end
        tick();
        bus.key_valid = 1'b0;
        check_bit("done_keys_valid", bus.keys_valid, 1'b1);
        check_bit("done_busy", bus.busy, 1'b0);
        check_bit("done_key_ready", bus.key_ready, 1'b1);

        bus.rk_idx = 4'd0;  tick(); check_rk("fips_rk0", bus.rk, 128'h000102030405060708090a0b0c0d0e0f);
        bus.rk_idx = 4'd1;  tick(); check_rk("fips_rk1", bus.rk, 128'h101112131415161718191a1b1c1d1e1f);
        bus.rk_idx = 4'd2;  tick(); check_rk("fips_rk2", bus.rk, 128'ha573c29fa176c498a97fce93a572c09c);
        bus.rk_idx = 4'd14; tick(); check_rk("fips_rk14", bus.rk, 128'h24fc79ccbf0979e9371ac23c6d68de36);
        bus.rk_idx = 4'd15; tick(); check_rk("idx15_rk", bus.rk, 128'h0);
        check_bit("idx15_kv", bus.keys_valid, 1'b1);

        // Descending sweep, one index per cycle; known slots checked on arrival.
        for (int i = 14; i >= 0; i--) begin
            bus.rk_idx = 4'(i);
            tick();
            exp_rk = 'x;
            case (i)
                14: exp_rk = 128'h24fc79ccbf0979e9371ac23c6d68de36;
                2:  exp_rk = 128'ha573c29fa176c498a97fce93a572c09c;
                1:  exp_rk = 128'h101112131415161718191a1b1c1d1e1f;
                0:  exp_rk = 128'h000102030405060708090a0b0c0d0e0f;
                default: ;
            endcase
            if (i == 14 || i <= 2) check_rk($sformatf("sweep_rk%0d", i), bus.rk, exp_rk);
        end

        // Rekey from DONE with the all-zero key.
        bus.key       = '0;
        bus.key_valid = 1'b1;
        tick();
        bus.key_valid = 1'b0;
        check_bit("rekey_kv_drop", bus.keys_valid, 1'b0);
        check_bit("rekey_busy", bus.busy, 1'b1);
        for (int i = 1; i <= 6; i++) tick();
        check_bit("rekey_kv_early", bus.keys_valid, 1'b0);
        tick();
        check_bit("rekey_kv_rise", bus.keys_valid, 1'b1);
        bus.rk_idx = 4'd2; tick(); check_rk("zero_rk2", bus.rk, 128'h62636363626363636263636362636363);
        bus.rk_idx = 4'd1; tick(); check_rk("zero_rk1", bus.rk, 128'h0);

        // Reset at step 3 of an expansion.
        bus.key       = FIPS_KEY;
        bus.key_valid = 1'b1;
        tick();
        bus.key_valid = 1'b0;
        tick(); tick(); tick();
        check_bit("pre_abort_busy", bus.busy, 1'b1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_bit("abort_busy", bus.busy, 1'b0);
        check_bit("abort_key_ready", bus.key_ready, 1'b1);
        check_bit("abort_kv", bus.keys_valid, 1'b0);
        bus.rk_idx = 4'd0;  tick(); check_rk("abort_rk0", bus.rk, 128'h0);
        bus.rk_idx = 4'd2;  tick(); check_rk("abort_rk2", bus.rk, 128'h0);
        bus.rk_idx = 4'd7;  tick(); check_rk("abort_rk7", bus.rk, 128'h0);
        bus.rk_idx = 4'd14; tick(); check_rk("abort_rk14", bus.rk, 128'h0);
        for (int i = 0; i < 8; i++) begin
            tick();
            check_bit($sformatf("abort_kv_hold_%0d", i), bus.keys_valid, 1'b0);
        end

        // Reset wins over a simultaneous key offer.
        rst_n         = 1'b0;
        bus.key       = FIPS_KEY;
        bus.key_valid = 1'b1;
        tick();
        check_bit("rst_prio_busy", bus.busy, 1'b0);
        check_bit("rst_prio_ready", bus.key_ready, 1'b1);
        bus.key_valid = 1'b0;
        rst_n         = 1'b1;
        bus.rk_idx    = 4'd0;
        tick();
        check_rk("rst_prio_rk0", bus.rk, 128'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
